// File: rtl/timer_stats_pkg.sv
// Shared types and elaboration helpers for the interval timer / statistics engine.
package timer_stats_pkg;

  typedef enum logic {
    IDLE_ST = 1'b0,
    MSMT_ST = 1'b1
  } state_e;

  // MIN_VALUE resets to all-ones; the top slices this to its counter width.
  localparam int unsigned MAX_CNT_W = 64;
  localparam logic [MAX_CNT_W-1:0] MIN_RST_VAL = '1;

  // The accumulator must hold a full window of all-ones samples without wrapping.
  function automatic bit acc_w_ok(input int cnt_w, input int log2_w, input int acc_w);
    return acc_w >= cnt_w + (1 << log2_w) - 1;
  endfunction

endpackage

// File: rtl/timer_stats_edge_det.sv
// Registered rising-edge detector; the event is high the cycle after the input rises.
module timer_stats_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in_sig,
  output logic evt
);

  logic prev_q, prev_d;
  logic evt_q, evt_d;

  always_comb begin
    prev_d = in_sig;
    evt_d  = in_sig & ~prev_q;
  end

  // History clears on reset so a level already high at release yields an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      evt_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      evt_q  <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/timer_stats_engine.sv
// Start/stop interval timer with power-of-two windowed averaging and min/max/count stats.
module timer_stats_engine
  import timer_stats_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int LOG2_W = 5,
  parameter int ACC_W  = 64
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              START_TIMER,
  input  logic              STOP_TIMER,
  input  logic              ABORT,
  input  logic              AVG_ENABLE,
  input  logic [LOG2_W-1:0] AVG_LOG2,
  input  logic              CLEAR_STATS,
  output logic              BUSY,
  output logic [CNT_W-1:0]  MSMT_VALUE,
  output logic              MSMT_VALID,
  output logic              MSMT_OVF,
  output logic [CNT_W-1:0]  AVG_VALUE,
  output logic              AVG_VALID,
  output logic [CNT_W-1:0]  MIN_VALUE,
  output logic [CNT_W-1:0]  MAX_VALUE,
  output logic [31:0]       MSMT_COUNT,
  output logic              STATS_OVF
);

  localparam int WC_W = 1 << LOG2_W;
  localparam logic [WC_W-1:0] WC_ONE = {{(WC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MIN_RST = MIN_RST_VAL[CNT_W-1:0];

  if (!acc_w_ok(CNT_W, LOG2_W, ACC_W) || CNT_W > MAX_CNT_W) begin : g_bad_params
    $error("timer_stats_engine: ACC_W too small for CNT_W/LOG2_W, or CNT_W too wide");
  end

  logic start_evt, stop_evt, en_evt;

  timer_stats_edge_det u_start_det (.clk(CLK), .rst_n(RESETN), .in_sig(START_TIMER), .evt(start_evt));
  timer_stats_edge_det u_stop_det  (.clk(CLK), .rst_n(RESETN), .in_sig(STOP_TIMER),  .evt(stop_evt));
  timer_stats_edge_det u_en_det    (.clk(CLK), .rst_n(RESETN), .in_sig(AVG_ENABLE),  .evt(en_evt));

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   msmt_value_q, msmt_value_d;
  logic               msmt_valid_q, msmt_valid_d;
  logic               msmt_ovf_q, msmt_ovf_d;
  logic [CNT_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]   max_q, max_d;
  logic [31:0]        count_q, count_d;
  logic               stats_ovf_q, stats_ovf_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WC_W-1:0]    wcnt_q, wcnt_d;
  logic [LOG2_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]   avg_value_q, avg_value_d;
  logic               avg_valid_q, avg_valid_d;

  logic               cnt_at_max;
  logic [CNT_W-1:0]   cnt_next;
  logic               ovf_next;
  logic               done;

  // Counter and FSM. The interval is reported from cnt_next so that the
  // cycle of the stop event itself is counted.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    ovf_d      = 1'b0;
    done       = 1'b0;
    cnt_at_max = &cnt_q;
    cnt_next   = cnt_at_max ? cnt_q : cnt_q + CNT_W'(1);
    ovf_next   = ovf_q | cnt_at_max;
    case (state_q)
      IDLE_ST: begin
        if (start_evt) state_d = MSMT_ST;
      end
      MSMT_ST: begin
        cnt_d = cnt_next;
        ovf_d = ovf_next;
        if (ABORT) begin
          state_d = IDLE_ST;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (stop_evt) begin
          state_d = IDLE_ST;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE_ST;
    endcase

    msmt_valid_d = done;
    msmt_value_d = done ? cnt_next : msmt_value_q;
    msmt_ovf_d   = done ? ovf_next : msmt_ovf_q;
  end

  // Min/max/count statistics; a coincident clear drops the sample.
  always_comb begin
    min_d       = min_q;
    max_d       = max_q;
    count_d     = count_q;
    stats_ovf_d = stats_ovf_q;
    if (CLEAR_STATS) begin
      min_d       = MIN_RST;
      max_d       = '0;
      count_d     = '0;
      stats_ovf_d = 1'b0;
    end else if (msmt_valid_q) begin
      count_d     = count_q + 32'd1;
      stats_ovf_d = stats_ovf_q | msmt_ovf_q;
      if (msmt_value_q < min_q) min_d = msmt_value_q;
      if (msmt_value_q > max_q) max_d = msmt_value_q;
    end
  end

  logic [LOG2_W-1:0] k_eff;
  logic [WC_W-1:0]   win_max;
  logic [ACC_W-1:0]  acc_sum;

  // Windowed averaging; k only changes on enable edge or window completion.
  always_comb begin
    k_eff       = en_evt ? AVG_LOG2 : k_q;
    k_d         = k_eff;
    win_max     = (WC_ONE << k_eff) - WC_ONE;
    acc_sum     = acc_q + ACC_W'(msmt_value_q);
    acc_d       = acc_q;
    wcnt_d      = wcnt_q;
    avg_valid_d = 1'b0;
    avg_value_d = avg_value_q;
    if (!AVG_ENABLE) begin
      acc_d  = '0;
      wcnt_d = '0;
    end else if (msmt_valid_q) begin
      if (wcnt_q == win_max) begin
        avg_value_d = CNT_W'(acc_sum >> k_eff);
        avg_valid_d = 1'b1;
        acc_d       = '0;
        wcnt_d      = '0;
        k_d         = AVG_LOG2;
      end else begin
        acc_d  = acc_sum;
        wcnt_d = wcnt_q + WC_ONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= IDLE_ST;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      msmt_value_q <= '0;
      msmt_valid_q <= 1'b0;
      msmt_ovf_q   <= 1'b0;
      min_q        <= MIN_RST;
      max_q        <= '0;
      count_q      <= '0;
      stats_ovf_q  <= 1'b0;
      acc_q        <= '0;
      wcnt_q       <= '0;
      k_q          <= '0;
      avg_value_q  <= '0;
      avg_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      msmt_value_q <= msmt_value_d;
      msmt_valid_q <= msmt_valid_d;
      msmt_ovf_q   <= msmt_ovf_d;
      min_q        <= min_d;
      max_q        <= max_d;
      count_q      <= count_d;
      stats_ovf_q  <= stats_ovf_d;
      acc_q        <= acc_d;
      wcnt_q       <= wcnt_d;
      k_q          <= k_d;
      avg_value_q  <= avg_value_d;
      avg_valid_q  <= avg_valid_d;
    end
  end

  assign BUSY       = (state_q == MSMT_ST);
  assign MSMT_VALUE = msmt_value_q;
  assign MSMT_VALID = msmt_valid_q;
  assign MSMT_OVF   = msmt_ovf_q;
  assign AVG_VALUE  = avg_value_q;
  assign AVG_VALID  = avg_valid_q;
  assign MIN_VALUE  = min_q;
  assign MAX_VALUE  = max_q;
  assign MSMT_COUNT = count_q;
  assign STATS_OVF  = stats_ovf_q;

endmodule

// File: doc/timer_stats_engine.md
Name: timer_stats_engine

Overview:
Parametrised cycle-accurate interval timer with windowed averaging and min/max statistics. It measures the CLK cycles between a rising edge on START_TIMER and a rising edge on STOP_TIMER. Results are accumulated over a programmable power-of-two window, and running min/max values are tracked. It sits behind the AXI-Lite register slave of the timer subsystem; all inputs come from software-written registers or from trigger logic in the same clock domain.

Parameters:
CNT_W, 32, width of the interval counter and of every measurement output
LOG2_W, 5, width of AVG_LOG2; maximum window is 2^(2^LOG2_W-1) samples
ACC_W, 64, accumulator width; must satisfy ACC_W >= CNT_W + 2^LOG2_W - 1, otherwise elaboration fails

Ports:
CLK  in  1  clock
RESETN  in  1  asynchronous active-low reset
START_TIMER  in  1  level; a rising edge starts a measurement
STOP_TIMER  in  1  level; a rising edge ends a measurement
ABORT  in  1  pulse; cancels the measurement in progress
AVG_ENABLE  in  1  level; enables windowed averaging
AVG_LOG2  in  LOG2_W  window size exponent k; window N = 2^k
CLEAR_STATS  in  1  pulse; clears min, max, MSMT_COUNT and STATS_OVF
BUSY  out  1  high while in MSMT state
MSMT_VALUE  out  CNT_W  last completed interval
MSMT_VALID  out  1  one-cycle pulse when MSMT_VALUE updates
MSMT_OVF  out  1  last measurement saturated
AVG_VALUE  out  CNT_W  last window average
AVG_VALID  out  1  one-cycle pulse when AVG_VALUE updates
MIN_VALUE  out  CNT_W  minimum measurement since reset or clear
MAX_VALUE  out  CNT_W  maximum measurement since reset or clear
MSMT_COUNT  out  32  completed measurements since reset or clear; wraps at 2^32
STATS_OVF  out  1  sticky: a saturated sample has entered the statistics

Behaviour:
- Reset (asynchronous, any time, including mid-measurement): FSM returns to IDLE. All outputs go to 0 except MIN_VALUE, which goes to all-ones. Accumulator, window count and latched k are cleared. Edge-detector history registers are cleared, so an input that is already high at reset release produces an edge.
- Edge detection: rising edge = input high in cycle t and low in cycle t-1. The detected event is registered and acted on in cycle t+1.
- FSM states:
  - IDLE -> MSMT on a start event. In IDLE, stop and ABORT are ignored.
  - MSMT -> IDLE on a stop event or on ABORT. In MSMT, start events are ignored.
  - If a start and a stop edge fall in the same cycle while in IDLE, the FSM enters MSMT and that stop is discarded.
  - If ABORT and a stop event coincide in MSMT, ABORT wins: no MSMT_VALID.
- Counter: cleared in IDLE and increments by 1 each cycle in MSMT. At all-ones it holds and sets an internal overflow flag.
  - Edge sampled at cycle a, stop edge sampled at cycle s: MSMT_VALUE = s - a.
  - MSMT_VALID pulses in cycle s+2, together with MSMT_VALUE and MSMT_OVF.
- Statistics update on the same cycle as MSMT_VALID (visible one cycle later): MSMT_COUNT += 1; MIN_VALUE/MAX_VALUE compare and update; STATS_OVF is set if MSMT_OVF. Saturated samples are included at the all-ones value.
- CLEAR_STATS: takes effect the next cycle. If it coincides with a valid, the clear wins and the sample is dropped from min/max/count only.
- Averaging:
  - k is latched from AVG_LOG2 on the AVG_ENABLE rising edge and at each window completion. Changing AVG_LOG2 mid-window has no effect until then.
  - Each valid adds zero-extended MSMT_VALUE to the accumulator.
  - On the Nth valid of the window, AVG_VALUE = (acc + sample) >> k, truncated to CNT_W. AVG_VALID pulses one cycle after that MSMT_VALID.
  - In that same cycle the accumulator reloads to 0 and the window count to 0, so the next sample starts a new window with nothing lost.
  - k = 0: every sample produces an average equal to the sample.
- AVG_ENABLE low: accumulator and window count are held at 0 and no AVG_VALID is produced. AVG_VALUE holds its last value.
- Outputs MSMT_VALUE, AVG_VALUE, MIN_VALUE and MAX_VALUE hold their value between updates.

Decomposition:
- Package timer_stats_pkg holds:
  - FSM enum type (IDLE_ST, MSMT_ST)
  - function that checks the minimum legal ACC_W
  - constant for the reset value of MIN_VALUE
- One sub-module: timer_stats_edge_det. It is a registered rising-edge detector and is instantiated for START_TIMER, STOP_TIMER and AVG_ENABLE.
- Averaging accumulator and min/max logic stay in the top module.

Test Plan:
- Basic interval: start edge at cycle 10, stop edge at cycle 110 -> MSMT_VALID in cycle 112, MSMT_VALUE=100, MSMT_OVF=0, MSMT_COUNT=1, MIN=MAX=100.
- Averaging: AVG_ENABLE=1, k=2, intervals 10,20,30,41 -> single AVG_VALID one cycle after the 4th MSMT_VALID, AVG_VALUE=25. The 5th interval of 8 starts a new window.
- Saturation: CNT_W=8, interval of 300 cycles -> MSMT_VALUE=255, MSMT_OVF=1, STATS_OVF=1 (sticky until CLEAR_STATS).
- Abort and conflicts: ABORT at the same cycle as a stop event -> no MSMT_VALID, BUSY low next cycle. Start+stop edges together in IDLE -> BUSY high, measurement continues.
- Reset mid-measurement: RESETN low at cycle 50 of a measurement -> immediate outputs 0, MIN all-ones, no MSMT_VALID after release.
- CLEAR_STATS coinciding with MSMT_VALID -> MSMT_COUNT=0, MIN all-ones, MAX=0 next cycle; MSMT_VALUE still updated.
